// File: rtl/hdmi_reset_seq.sv
// Reset/bring-up sequencer for the HDMI TMDS clock chain: pulses rPLL reset, qualifies lock,
// then releases serializer and pixel-domain resets in order; re-sequences on lock loss.
module hdmi_reset_seq #(
    parameter int LOCK_STABLE_CYCLES  = 2700,
    parameter int LOCK_TIMEOUT_CYCLES = 27000,
    parameter int PLL_RESET_CYCLES    = 27,
    parameter int SER_TO_PIX_CYCLES   = 16,
    parameter int CNT_W               = 16
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       ser_rst,
    output logic       pix_rst_n,
    output logic       ready,
    output logic [3:0] retry_count
);

    localparam logic [2:0] ST_PLL_RST     = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK   = 3'd1;
    localparam logic [2:0] ST_STABLE      = 3'd2;
    localparam logic [2:0] ST_SER_RELEASE = 3'd3;
    localparam logic [2:0] ST_RUN         = 3'd4;

    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S2P_LAST = CNT_W'(SER_TO_PIX_CYCLES - 1);

    logic             lock_meta_q;
    logic             lock_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             pll_reset_q, ser_rst_q, pix_rst_n_q, ready_q;

    // pll_lock comes from the PLL domain; only the second flop is used downstream
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_PLL_RST;
                    if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q)              state_d = ST_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = ST_SER_RELEASE;
            end
            ST_SER_RELEASE: begin
                if (!lock_s_q)              state_d = ST_WAIT_LOCK;
                else if (cnt_q == S2P_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s_q) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_PLL_RST;
        endcase
    end

    // Counter restarts on every state change and holds in RUN
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)     cnt_d = '0;
        else if (state_q != ST_RUN) cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            ser_rst_q   <= 1'b1;
            pix_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= (state_d == ST_PLL_RST);
            ser_rst_q   <= (state_d == ST_PLL_RST) || (state_d == ST_WAIT_LOCK) ||
                           (state_d == ST_STABLE);
            pix_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign ser_rst     = ser_rst_q;
    assign pix_rst_n   = pix_rst_n_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_hdmi_reset_seq.sv
// Scoreboard bench for hdmi_reset_seq: a run-length reference model pushes expected outputs
// every clock edge, a negedge monitor pops and compares them against the DUT.
module tb_hdmi_reset_seq;

    localparam int LSC = 8;
    localparam int LTC = 20;
    localparam int PRC = 4;
    localparam int STP = 3;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic       ser_rst;
    logic       pix_rst_n;
    logic       ready;
    logic [3:0] retry_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       pr;
        logic       sr;
        logic       pn;
        logic       rd;
        logic [3:0] rc;
    } exp_t;

    exp_t exp_q[$];

    hdmi_reset_seq #(
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT_CYCLES(LTC),
        .PLL_RESET_CYCLES   (PRC),
        .SER_TO_PIX_CYCLES  (STP),
        .CNT_W              (16)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .ser_rst    (ser_rst),
        .pix_rst_n  (pix_rst_n),
        .ready      (ready),
        .retry_count(retry_count)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how long the synchronised lock has been high or low,
    // plus the remaining PLL reset pulse length, and derives outputs from those run lengths.
    int   m_left = PRC;
    int   m_hi = 0;
    int   m_lo = 0;
    int   m_retry = 0;
    bit   m_locked = 1'b0;
    bit   m_lk;
    bit   m_hist[$];
    exp_t m_e;

    always @(posedge clkin) begin
        if (!rst_n) begin
            m_left   = PRC;
            m_locked = 1'b0;
            m_hi     = 0;
            m_lo     = 0;
            m_retry  = 0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
        end else begin
            m_lk = m_hist.pop_front();
            m_hist.push_back(pll_lock);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_locked = 1'b0;
                    m_lo     = 0;
                end
            end else if (m_lk) begin
                if (!m_locked) begin
                    m_locked = 1'b1;
                    m_hi     = 0;
                end else if (m_hi < LSC + STP) begin
                    m_hi++;
                end
            end else begin
                if (m_locked) begin
                    m_locked = 1'b0;
                    m_lo     = 0;
                end else begin
                    m_lo++;
                    if (m_lo == LTC) begin
                        m_left = PRC;
                        if (m_retry < 15) m_retry++;
                    end
                end
            end
        end
        m_e.pr = (m_left > 0);
        m_e.sr = !(m_left == 0 && m_locked && m_hi >= LSC);
        m_e.rd = (m_left == 0 && m_locked && m_hi >= LSC + STP);
        m_e.pn = m_e.rd;
        m_e.rc = 4'(m_retry);
        exp_q.push_back(m_e);
    end

    exp_t mon_e;
    always @(negedge clkin) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_pll_reset", int'(pll_reset), int'(mon_e.pr));
            chk("sb_ser_rst", int'(ser_rst), int'(mon_e.sr));
            chk("sb_pix_rst_n", int'(pix_rst_n), int'(mon_e.pn));
            chk("sb_ready", int'(ready), int'(mon_e.rd));
            chk("sb_retry_count", int'(retry_count), int'(mon_e.rc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clkin);
            #1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pll_reset"}, int'(pll_reset), 1);
        chk({tag, "_ser_rst"}, int'(ser_rst), 1);
        chk({tag, "_pix_rst_n"}, int'(pix_rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_retry"}, int'(retry_count), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        cyc(3);
        chk_reset_vals("por");

        // Power-on, lock arrives 10 cycles after reset release
        rst_n = 1'b1;
        cyc(10);
        pll_lock = 1'b1;
        cyc(40);
        chk("acq_ready", int'(ready), 1);
        chk("acq_retry", int'(retry_count), 0);

        // Long lock absence: two timeouts
        pll_lock = 1'b0;
        cyc(60);
        chk("tmo_retry", int'(retry_count), 2);
        chk("tmo_ser_rst", int'(ser_rst), 1);

        // Short glitch then real lock
        pll_lock = 1'b1;
        cyc(5);
        pll_lock = 1'b0;
        cyc(3);
        pll_lock = 1'b1;
        cyc(40);
        chk("glitch_ready", int'(ready), 1);

        // One-cycle lock loss in RUN
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(2);
        chk("loss_ready", int'(ready), 0);
        chk("loss_ser_rst", int'(ser_rst), 1);
        chk("loss_pix_rst_n", int'(pix_rst_n), 0);
        chk("loss_pll_reset", int'(pll_reset), 0);
        cyc(30);
        chk("reacq_ready", int'(ready), 1);

        // Randomised lock behaviour
        repeat (30) begin
            pll_lock = 1'($urandom_range(0, 1));
            cyc(int'($urandom_range(1, 30)));
        end

        // Enough timeouts to saturate the retry counter
        pll_lock = 1'b0;
        cyc(24 * 20 + 10);
        chk("sat_retry", int'(retry_count), 15);

        // Reach RUN, drop lock briefly, then assert async reset while in STABLE
        pll_lock = 1'b1;
        cyc(40);
        chk("pre_async_ready", int'(ready), 1);
        pll_lock = 1'b0;
        cyc(1);
        pll_lock = 1'b1;
        cyc(6);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        cyc(2);
        rst_n = 1'b1;
        cyc(25);
        chk("post_async_ready", int'(ready), 1);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdmi_reset_seq.md
# hdmi_reset_seq

Reset and bring-up sequencer for the HDMI TMDS clocking chain. It runs on the 27 MHz board reference clock and drives the rPLL `RESET` input. It watches the PLL `lock` output and releases resets in order: first the 10:1 serializer and divide-by-5 clock divider, then pixel-domain logic. It also detects lock loss, re-sequences after it, and retries the PLL when lock times out.

## Interface
- `LOCK_STABLE_CYCLES`, default 2700: cycles `lock` must stay high continuously before resets are released (100 µs at 27 MHz).
- `LOCK_TIMEOUT_CYCLES`, default 27000: cycles to wait for lock before pulsing PLL reset again (1 ms).
- `PLL_RESET_CYCLES`, default 27: width of the `pll_reset` pulse (1 µs).
- `SER_TO_PIX_CYCLES`, default 16: delay from `ser_rst` release to `pix_rst_n` release.
- `CNT_W`, default 16: width of the shared counter. Must hold the largest cycle parameter minus 1.
- `clkin`, input, 1: 27 MHz reference clock, the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset. Deassertion is synchronised to `clkin` upstream.
- `pll_lock`, input, 1: rPLL `LOCK`, asynchronous to `clkin`.
- `pll_reset`, output, 1: to rPLL `RESET`, active high.
- `ser_rst`, output, 1: active-high reset for the OSER10 serializers and CLKDIV.
- `pix_rst_n`, output, 1: active-low reset for pixel-clock logic. The consumer resynchronises it into its own domain.
- `ready`, output, 1: high when the whole chain is running.
- `retry_count`, output, 4: number of lock-timeout retries, saturating.

## Operation
- `pll_lock` passes through a 2-flop synchroniser (both flops reset to 0). The FSM uses only the synchronised signal `lock_s`.
- There is one counter, `cnt`. It clears to 0 on every state change.
- **PLL_RST**
  - Outputs: `pll_reset=1`, `ser_rst=1`, `pix_rst_n=0`, `ready=0`.
  - Leaves for WAIT_LOCK when `cnt==PLL_RESET_CYCLES-1`.
- **WAIT_LOCK**
  - Outputs: `pll_reset=0`, `ser_rst=1`, `pix_rst_n=0`, `ready=0`.
  - If `lock_s` is high, goes to STABLE.
  - Otherwise, when `cnt==LOCK_TIMEOUT_CYCLES-1`, goes to PLL_RST and increments `retry_count` (saturates at 15).
- **STABLE**
  - Outputs are the same as in WAIT_LOCK.
  - If `lock_s` is low, goes to WAIT_LOCK with the timeout restarted.
  - Otherwise, when `cnt==LOCK_STABLE_CYCLES-1`, goes to SER_RELEASE.
- **SER_RELEASE**
  - Outputs: `ser_rst=0`, `pix_rst_n=0`, `ready=0`.
  - When `cnt==SER_TO_PIX_CYCLES-1`, goes to RUN.
- **RUN**
  - Outputs: `ser_rst=0`, `pix_rst_n=1`, `ready=1`.
  - The counter is idle.
- **Lock loss in SER_RELEASE or RUN:** when `lock_s` is low, the FSM goes to WAIT_LOCK. `ser_rst=1`, `pix_rst_n=0` and `ready=0` take effect on that same edge. `pll_reset` is not pulsed.
- **Precedence:** lock loss beats counter terminal count. In WAIT_LOCK, `lock_s=1` beats timeout on the same cycle.
- `retry_count` clears only on `rst_n`. It does not clear on a successful lock.

## Timing
- **Reset values** while `rst_n=0`: state PLL_RST, `cnt=0`, `pll_reset=1`, `ser_rst=1`, `pix_rst_n=0`, `ready=0`, `retry_count=0`.
- **Registered outputs:** all outputs are registers loaded on the same edge as the state register, decoded from the next state. There is no combinational path from input to output.
- **Power-on:** `pll_reset` is high for exactly `PLL_RESET_CYCLES` edges after reset release, counting the first edge.
- **Lock acquisition:** `pll_lock` rises before edge E0. `lock_s` is high after E1. STABLE is entered at E2.
  - `ser_rst` falls at E2+`LOCK_STABLE_CYCLES`.
  - `pix_rst_n` and `ready` rise at E2+`LOCK_STABLE_CYCLES`+`SER_TO_PIX_CYCLES`.
- **Lock loss:** `pll_lock` falls before edge L0. Outputs return to their reset levels at L2, a latency of 2 edges.
- **Timeout:** in WAIT_LOCK with no lock, `pll_reset` rises exactly `LOCK_TIMEOUT_CYCLES` edges after WAIT_LOCK entry.
- **Glitch filter:** a high pulse on `pll_lock` shorter than `LOCK_STABLE_CYCLES` never releases `ser_rst`.
- **Async reset mid-sequence:** `rst_n` asserted in any state forces reset values immediately.

## Test plan
Benches use `LOCK_STABLE_CYCLES=8`, `LOCK_TIMEOUT_CYCLES=20`, `PLL_RESET_CYCLES=4`, `SER_TO_PIX_CYCLES=3`.
- Release `rst_n` and raise `pll_lock` 10 cycles later, holding it high -> `pll_reset` is high for 4 edges; `ser_rst` falls 10 edges after the lock rise; `pix_rst_n` and `ready` rise 3 edges later; `retry_count=0`.
- Keep `pll_lock` low for 60 cycles -> `pll_reset` pulses (4 cycles wide) every 24 cycles; `retry_count` goes 1, 2; `ser_rst` stays 1 throughout.
- Give `pll_lock` a 5-cycle high pulse, then low, then hold it high -> no release during the pulse; the full 8-cycle qualification restarts from the second rise.
- In RUN, drop `pll_lock` for 1 cycle -> `ready=0`, `ser_rst=1` and `pix_rst_n=0` 2 edges later; `pll_reset` stays 0; re-release follows the acquisition timing.
- Force 20 timeouts -> `retry_count` saturates at 15; assert `rst_n=0` mid-STABLE -> all outputs return to their reset values with no clock edge.
